median_window_feeder: RTL and testbench
=======================================

Name: median_window_feeder

Overview:
- Upstream stage of the 5-input median sorter: collects a serial stream of DATA_W-bit samples into a 5-deep sliding window.
- Presents all five window slots in parallel to the sorter's five inputs, with a valid/ready handshake and optional edge padding at stream start.
- Window outputs are registered, so the combinational sorter sees stable operands for a full cycle.

Parameters:
- DATA_W, 6, sample width in bits; must match the sorter input width.
- EDGE_PAD, 0, 0 = no window until 5 real samples are held; 1 = first sample after empty is replicated into all 5 slots and a window is emitted at once.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of window and fill state.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  incoming sample.
- out_valid  output  1  window registers hold a new, unconsumed window.
- out_ready  input  1  downstream consumes the window this cycle.
- out_num0..out_num4  output  DATA_W each  window slots; out_num0 is oldest, out_num4 is newest; wired to sorter in_num0..in_num4.
- fill_cnt  output  3  number of valid samples held, 0..5.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_num0..4 = 0, out_valid = 0, fill_cnt = 0, state = EMPTY.
  - Combinational in_ready is 1 during reset.
- Accept rule: a sample is accepted on a clk edge when in_valid && in_ready && !clear.
- in_ready = !out_valid || out_ready, combinational.
  - No skid buffer.
  - in_ready is independent of in_valid.
- Shift on accept: slot0<=slot1, slot1<=slot2, slot2<=slot3, slot3<=slot4, slot4<=in_data.
- fill_cnt saturates at 5.
- States:
  - EMPTY (fill_cnt=0):
    - EDGE_PAD=0: accept -> FILL, slot4=in_data, fill_cnt=1.
    - EDGE_PAD=1: accept -> FULL, all five slots = in_data, fill_cnt=5, out_valid=1 next cycle.
  - FILL (fill_cnt 1..4): accept shifts; when fill_cnt becomes 5 -> FULL and out_valid=1 next cycle.
    - Slots not yet written stay 0.
  - FULL: every accept shifts, keeps fill_cnt=5, and sets out_valid=1 next cycle.
- out_valid next-state, evaluated in priority order:
  - clear -> 0.
  - accept that yields a full window -> 1.
  - out_ready -> 0.
  - otherwise hold.
- Latency: one cycle from the accepting edge to the new window on out_num* with out_valid=1.
- Throughput: one window per cycle when out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0:
  - in_ready=0.
  - out_num* and out_valid hold stable.
  - No sample is dropped or overwritten.
- Consume and accept in the same cycle (out_valid=1, out_ready=1, in_valid=1): the window is consumed and the next window is loaded on the same edge; out_valid stays 1.
- clear (synchronous, highest priority, overrides accept in the same cycle):
  - Next edge: out_num* = 0, out_valid = 0, fill_cnt = 0, state = EMPTY.
  - A sample offered in the clear cycle is not accepted, even though in_ready may be 1.
- Reset mid-stream discards all state immediately; no partial window is emitted after release.
- Unsigned data; no arithmetic beyond the fill counter; the counter never wraps.

Test Plan:
- EDGE_PAD=0, out_ready=1, stream 10,20,30,40,50,60:
  - out_valid first high the cycle after 50 is accepted, with out_num0..4 = 10,20,30,40,50.
  - Next cycle = 20,30,40,50,60.
  - fill_cnt reads 1,2,3,4,5,5.
- EDGE_PAD=1, single sample 33 from EMPTY -> next cycle out_valid=1, out_num0..4 all 33, fill_cnt=5.
  - A following 7 gives 33,33,33,33,7.
- Backpressure: window valid and out_ready=0 for 3 cycles with in_valid=1, in_data=63:
  - in_ready=0 throughout; outputs unchanged.
  - Raising out_ready gives in_ready=1; the 63 is accepted and appears in slot4 next cycle.
- clear asserted in the same cycle as an accept of 12 while FULL:
  - Next cycle out_valid=0, fill_cnt=0, all slots 0; 12 is not captured.
  - EDGE_PAD=0 then requires 5 new samples before out_valid=1.
- rst_n pulsed low asynchronously mid-cycle with fill_cnt=3 -> outputs clear immediately without waiting for clk.
  - After release, 5 new samples are needed before the first window.
- Integration with the median sorter: windows {5,63,0,17,42} and {1,1,2,2,2} -> sorter out_num 17 then 2, one cycle after each final accept.

Source files
------------

// File: rtl/median_window_feeder.sv
// median_window_feeder
//   Collects a serial stream of DATA_W-bit samples into a 5-deep sliding
//   window and presents all five slots in parallel, from registers, to the
//   5-input median sorter.
//
//   Handshake: a transfer happens on a rising clk edge when valid && ready.
//   in_ready does not depend on in_valid. An out_valid window stays
//   stable until out_ready is seen.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   clear              synchronous flush; overrides a same-cycle accept
//   in_valid/in_ready  sample handshake; in_ready = !out_valid || out_ready
//   in_data            incoming sample
//   out_valid          window registers hold a new, unconsumed window
//   out_ready          downstream consumes the window this cycle
//   out_num0..4        window slots, out_num0 oldest, out_num4 newest
//   fill_cnt           number of valid samples held, 0..5
module median_window_feeder #(
  parameter int DATA_W   = 6,
  parameter bit EDGE_PAD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_num0,
  output logic [DATA_W-1:0] out_num1,
  output logic [DATA_W-1:0] out_num2,
  output logic [DATA_W-1:0] out_num3,
  output logic [DATA_W-1:0] out_num4,
  output logic [2:0]        fill_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] slot_q [5];
  logic [DATA_W-1:0] slot_d [5];
  logic [2:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              accept;
  logic              win_full;

  // No skid buffer: a held window blocks new samples until it is consumed.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !clear;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    win_full = 1'b0;

    if (clear) begin
      state_d = ST_EMPTY;
      cnt_d   = 3'd0;
      for (int k = 0; k < 5; k++) slot_d[k] = '0;
    end else if (accept) begin
      // Default action is a shift toward slot0. Unwritten slots are still
      // zero while filling, so the shift also covers the first sample.
      for (int k = 0; k < 4; k++) slot_d[k] = slot_q[k+1];
      slot_d[4] = in_data;
      case (state_q)
        ST_EMPTY: begin
          if (EDGE_PAD) begin
            for (int k = 0; k < 5; k++) slot_d[k] = in_data;
            cnt_d    = 3'd5;
            state_d  = ST_FULL;
            win_full = 1'b1;
          end else begin
            cnt_d   = 3'd1;
            state_d = ST_FILL;
          end
        end
        ST_FILL: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd4) begin
            state_d  = ST_FULL;
            win_full = 1'b1;
          end
        end
        ST_FULL: begin
          win_full = 1'b1;
        end
        default: begin
          state_d = ST_EMPTY;
          cnt_d   = 3'd0;
        end
      endcase
    end

    // Priority: clear, then a newly completed window, then consumption.
    if (clear)          valid_d = 1'b0;
    else if (win_full)  valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    else                valid_d = valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      for (int k = 0; k < 5; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      for (int k = 0; k < 5; k++) slot_q[k] <= slot_d[k];
    end
  end

  assign out_valid = valid_q;
  assign fill_cnt  = cnt_q;
  assign out_num0  = slot_q[0];
  assign out_num1  = slot_q[1];
  assign out_num2  = slot_q[2];
  assign out_num3  = slot_q[3];
  assign out_num4  = slot_q[4];

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder: one instance without edge padding (index 0)
// and one with edge padding (index 1) share the same input stimulus. Each has
// a reference model that keeps the accepted samples in a queue and derives
// the window as the last five of them.
module tb_median_window_feeder;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  wire          o_ready [2];
  wire          o_valid [2];
  wire  [W-1:0] o_num [2][5];
  wire  [2:0]   o_cnt [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q [2][$];
  logic         exp_v [2];

  always #5 clk = ~clk;

  median_window_feeder #(.DATA_W(W), .EDGE_PAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(o_ready[0]), .in_data(in_data),
    .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_num0(o_num[0][0]), .out_num1(o_num[0][1]), .out_num2(o_num[0][2]),
    .out_num3(o_num[0][3]), .out_num4(o_num[0][4]), .fill_cnt(o_cnt[0])
  );

  median_window_feeder #(.DATA_W(W), .EDGE_PAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(o_ready[1]), .in_data(in_data),
    .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_num0(o_num[1][0]), .out_num1(o_num[1][1]), .out_num2(o_num[1][2]),
    .out_num3(o_num[1][3]), .out_num4(o_num[1][4]), .fill_cnt(o_cnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: window = last five accepted samples, zeros where missing.
  function automatic logic [W-1:0] exp_slot(int i, int k);
    int idx;
    idx = exp_q[i].size() - 5 + k;
    if (idx < 0) return '0;
    return exp_q[i][idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      exp_v[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic v, input logic [W-1:0] d,
                            input logic ordy, input logic clr);
    logic rdy;
    logic acc;
    rdy = !exp_v[i] || ordy;
    acc = v && rdy && !clr;
    if (clr) begin
      exp_q[i].delete();
      exp_v[i] = 1'b0;
    end else if (acc) begin
      if (i == 1 && exp_q[i].size() == 0) begin
        for (int k = 0; k < 5; k++) exp_q[i].push_back(d);
      end else begin
        exp_q[i].push_back(d);
      end
      while (exp_q[i].size() > 5) void'(exp_q[i].pop_front());
      if (exp_q[i].size() == 5) exp_v[i] = 1'b1;
    end else if (ordy) begin
      exp_v[i] = 1'b0;
    end
  endtask

  task automatic check_outs(input int i);
    chk($sformatf("dut%0d out_valid", i), o_valid[i], exp_v[i]);
    chk($sformatf("dut%0d fill_cnt", i), o_cnt[i], exp_q[i].size());
    for (int k = 0; k < 5; k++)
      chk($sformatf("dut%0d out_num%0d", i, k), o_num[i][k], exp_slot(i, k));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                      input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d in_ready", i), o_ready[i], !exp_v[i] || ordy);
      model_step(i, v, d, ordy, clr);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_outs(i);
    @(negedge clk);
  endtask

  function automatic int med5(input int a, input int b, input int c, input int d, input int e);
    int s [5];
    int t;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d; s[4] = e;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 4 - x; y++)
        if (s[y] > s[y+1]) begin
          t = s[y]; s[y] = s[y+1]; s[y+1] = t;
        end
    return s[2];
  endfunction

  initial begin
    int stream_a [6];
    int win_b [5];
    int win_c [5];
    stream_a = '{10, 20, 30, 40, 50, 60};
    win_b    = '{5, 63, 0, 17, 42};
    win_c    = '{1, 1, 2, 2, 2};

    // Clock/reset
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      check_outs(i);
      chk($sformatf("dut%0d rst in_ready", i), o_ready[i], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Plain stream, out_ready held high
    for (int n = 0; n < 6; n++) begin
      step(1'b1, W'(stream_a[n]), 1'b1, 1'b0);
      chk("a fill_cnt", o_cnt[0], (n < 5) ? n + 1 : 5);
      if (n == 4) begin
        chk("a first valid", o_valid[0], 1);
        for (int k = 0; k < 5; k++) chk("a first window", o_num[0][k], stream_a[k]);
      end
      if (n == 3) chk("a not yet valid", o_valid[0], 0);
    end
    for (int k = 0; k < 5; k++) chk("a second window", o_num[0][k], stream_a[k+1]);

    // Edge padding from empty
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 6'd33, 1'b1, 1'b0);
    chk("pad valid", o_valid[1], 1);
    chk("pad cnt", o_cnt[1], 5);
    for (int k = 0; k < 5; k++) chk("pad window", o_num[1][k], 33);
    step(1'b1, 6'd7, 1'b1, 1'b0);
    chk("pad next newest", o_num[1][4], 7);
    chk("pad next oldest", o_num[1][0], 33);

    // Fill the unpadded instance, then backpressure
    for (int n = 1; n <= 3; n++) step(1'b1, W'(n), 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 6'd63, 1'b0, 1'b0);
      chk("bp in_ready", o_ready[0], 0);
      chk("bp held newest", o_num[0][4], 3);
      chk("bp held valid", o_valid[0], 1);
    end
    step(1'b1, 6'd63, 1'b1, 1'b0);
    chk("bp release dut0", o_num[0][4], 63);
    chk("bp release dut1", o_num[1][4], 63);

    // Clear overriding an accept while full
    step(1'b1, 6'd12, 1'b1, 1'b1);
    chk("clr valid", o_valid[0], 0);
    chk("clr cnt", o_cnt[0], 0);
    chk("clr newest", o_num[0][4], 0);
    for (int n = 0; n < 5; n++) begin
      step(1'b1, W'($urandom_range(0, 63)), 1'b1, 1'b0);
      chk("clr refill valid", o_valid[0], (n == 4) ? 1 : 0);
    end

    // Windows as seen by the median sorter
    step(1'b0, '0, 1'b1, 1'b1);
    for (int n = 0; n < 5; n++) step(1'b1, W'(win_b[n]), 1'b1, 1'b0);
    chk("median b", med5(o_num[0][0], o_num[0][1], o_num[0][2], o_num[0][3], o_num[0][4]), 17);
    for (int n = 0; n < 5; n++) step(1'b1, W'(win_c[n]), 1'b1, 1'b0);
    chk("median c", med5(o_num[0][0], o_num[0][1], o_num[0][2], o_num[0][3], o_num[0][4]), 2);
    chk("median c valid", o_valid[0], 1);

    // Asynchronous reset mid-cycle with three samples held
    step(1'b0, '0, 1'b1, 1'b1);
    for (int n = 0; n < 3; n++) step(1'b1, W'(n + 40), 1'b1, 1'b0);
    chk("pre-reset cnt", o_cnt[0], 3);
    in_valid = 1'b0;
    clear    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check_outs(i);
      chk($sformatf("dut%0d async rst in_ready", i), o_ready[i], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step(1'b1, W'($urandom_range(0, 63)), 1'b1, 1'b0);
      chk("post-reset valid", o_valid[0], (n == 4) ? 1 : 0);
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, W'($urandom_range(0, 63)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
